// File: rtl/shift_add_multiply_4bits_if.sv
// Operand/result bundle for the sign-magnitude shift-add multiplier.
// Handshake: multiply_sel is a level request; multiply_finish stays high until multiply_sel drops.
interface shift_add_multiply_4bits_if #(
    parameter int WIDTH = 4
);
    logic                   multiply_sel;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic                   a_sign;
    logic                   b_sign;
    logic [2*WIDTH-1:0]     product;
    logic                   multiply_ovf;
    logic                   multiply_busy;
    logic                   multiply_finish;
    logic [1:0]             dbg_state;

    modport master (
        output multiply_sel, a_mag, b_mag, a_sign, b_sign,
        input  product, multiply_ovf, multiply_busy, multiply_finish, dbg_state
    );

    modport slave (
        input  multiply_sel, a_mag, b_mag, a_sign, b_sign,
        output product, multiply_ovf, multiply_busy, multiply_finish, dbg_state
    );
endinterface

// File: rtl/shift_add_multiply_4bits.sv
// Sequential sign-magnitude shift-add multiplier: WIDTH add/shift steps, then one sign step.
// All outputs are registered; operands are sampled only on the IDLE->RUN edge.
module shift_add_multiply_4bits #(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    shift_add_multiply_4bits_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [PW-1:0] NEG_LIMIT = PW'(1) << (PW - 1);
    localparam logic [PW-1:0] POS_LIMIT = NEG_LIMIT - PW'(1);

    logic [1:0]         r_state;
    logic [PW-1:0]      r_p;
    logic [PW-1:0]      r_m;
    logic [WIDTH-1:0]   r_q;
    logic [CW-1:0]      r_cnt;
    logic               r_s;
    logic [PW-1:0]      r_product;
    logic               r_ovf;
    logic               r_busy;
    logic               r_finish;
    logic               w_ovf;

    // A negative result may reach -2^(2W-1); a positive one only 2^(2W-1)-1.
    assign w_ovf = r_s ? (r_p > NEG_LIMIT) : (r_p > POS_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_p       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_s       <= 1'b0;
            r_product <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_finish  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.multiply_sel) begin
                        r_m      <= {{WIDTH{1'b0}}, bus.a_mag};
                        r_q      <= bus.b_mag;
                        r_s      <= bus.a_sign ^ bus.b_sign;
                        r_p      <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_finish <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_q[0]) begin
                        r_p <= r_p + r_m;
                    end
                    r_m   <= r_m << 1;
                    r_q   <= r_q >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    r_product <= r_s ? (-r_p) : r_p;
                    r_ovf     <= w_ovf;
                    r_busy    <= 1'b0;
                    r_finish  <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    // Restart requires sel to drop here first; product/ovf are kept.
                    if (!bus.multiply_sel) begin
                        r_finish <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.product         = r_product;
    assign bus.multiply_ovf    = r_ovf;
    assign bus.multiply_busy   = r_busy;
    assign bus.multiply_finish = r_finish;
    assign bus.dbg_state       = r_state;
endmodule

// File: tb/tb_shift_add_multiply_4bits.sv
// Bench for shift_add_multiply_4bits: directed vector table, corner sequences and random
// operations checked against an integer-arithmetic reference model.
module tb_shift_add_multiply_4bits;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_add_multiply_4bits_if #(.WIDTH(W)) bus();
    shift_add_multiply_4bits #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];   // {ovf, product}

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       as;
        logic       bs;
        logic [7:0] p;
        logic       ovf;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Signed product from plain integer arithmetic; range check on the true value.
    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic as, input logic bs);
        int v;
        logic o;
        v = int'(a) * int'(b);
        if (as ^ bs) v = -v;
        o = (v > 127) || (v < -128);
        return {o, 8'(v)};
    endfunction

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic as,
                          input logic bs, input bit drop_early, input int hold,
                          input string name);
        logic [8:0] exp;
        int n;
        int busy_bad;
        int hold_bad;
        exp = exp_q.pop_front();
        bus.a_mag = a;
        bus.b_mag = b;
        bus.a_sign = as;
        bus.b_sign = bs;
        bus.multiply_sel = 1'b1;
        n = 0;
        busy_bad = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1 && drop_early) bus.multiply_sel = 1'b0;
            if (n == 2) begin
                bus.a_mag = 4'($urandom);
                bus.b_mag = 4'($urandom);
                bus.a_sign = 1'($urandom);
                bus.b_sign = 1'($urandom);
            end
            if (bus.multiply_finish === 1'b1) break;
            if (bus.multiply_busy !== 1'b1) busy_bad++;
        end
        if (n >= 20) begin
            $display("FAIL %s timeout waiting for finish", name);
        end
        check({name, " latency"}, n, 6);
        check({name, " busy_run"}, busy_bad, 0);
        check({name, " product"}, int'(bus.product), int'(exp[7:0]));
        check({name, " ovf"}, int'(bus.multiply_ovf), int'(exp[8]));
        check({name, " busy_done"}, int'(bus.multiply_busy), 0);
        hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.multiply_finish !== 1'b1 || bus.multiply_busy !== 1'b0 ||
                bus.product !== exp[7:0] || bus.multiply_ovf !== exp[8]) hold_bad++;
        end
        if (hold > 0) check({name, " hold"}, hold_bad, 0);
        bus.multiply_sel = 1'b0;
        @(negedge clk);
        check({name, " finish_clear"}, int'(bus.multiply_finish), 0);
        check({name, " product_kept"}, int'(bus.product), int'(exp[7:0]));
    endtask

    initial begin
        vecs[0] = '{4'd3,  4'd5,  1'b0, 1'b0, 8'h0F, 1'b0};
        vecs[1] = '{4'd3,  4'd5,  1'b1, 1'b0, 8'hF1, 1'b0};
        vecs[2] = '{4'd8,  4'd8,  1'b1, 1'b1, 8'h40, 1'b0};
        vecs[3] = '{4'd8,  4'd15, 1'b1, 1'b0, 8'h88, 1'b0};
        vecs[4] = '{4'd15, 4'd15, 1'b0, 1'b0, 8'hE1, 1'b1};
        vecs[5] = '{4'd0,  4'd7,  1'b1, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{4'd15, 4'd15, 1'b1, 1'b0, 8'h1F, 1'b1};
        vecs[7] = '{4'd11, 4'd11, 1'b0, 1'b1, 8'h87, 1'b0};
        vecs[8] = '{4'd12, 4'd11, 1'b0, 1'b1, 8'h7C, 1'b1};
        vecs[9] = '{4'd13, 4'd10, 1'b0, 1'b0, 8'h82, 1'b1};

        rst = 1'b1;
        bus.multiply_sel = 1'b0;
        bus.a_mag = '0;
        bus.b_mag = '0;
        bus.a_sign = 1'b0;
        bus.b_sign = 1'b0;
        repeat (2) @(negedge clk);
        check("reset product", int'(bus.product), 0);
        check("reset ovf", int'(bus.multiply_ovf), 0);
        check("reset busy", int'(bus.multiply_busy), 0);
        check("reset finish", int'(bus.multiply_finish), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({vecs[i].ovf, vecs[i].p});
            run_op(vecs[i].a, vecs[i].b, vecs[i].as, vecs[i].bs, 1'b0, 0,
                   $sformatf("vec%0d", i));
        end

        // Hold in DONE for 10 cycles: finish and product stable, no restart.
        exp_q.push_back(9'h00F);
        run_op(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 10, "hold");

        // sel dropped during RUN: operation still completes, finish pulses once.
        exp_q.push_back({1'b0, 8'hF1});
        run_op(4'd3, 4'd5, 1'b0, 1'b1, 1'b1, 0, "drop_run");
        exp_q.push_back({1'b0, 8'h38});
        run_op(4'd7, 4'd8, 1'b0, 1'b0, 1'b0, 0, "after_drop");

        // Reset on E2 of an operation aborts it; previous product was nonzero.
        bus.a_mag = 4'd7;
        bus.b_mag = 4'd9;
        bus.a_sign = 1'b0;
        bus.b_sign = 1'b0;
        bus.multiply_sel = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst product", int'(bus.product), 0);
        check("midrst ovf", int'(bus.multiply_ovf), 0);
        check("midrst busy", int'(bus.multiply_busy), 0);
        check("midrst finish", int'(bus.multiply_finish), 0);
        rst = 1'b0;
        bus.multiply_sel = 1'b0;
        @(negedge clk);
        exp_q.push_back(model(4'd7, 4'd9, 1'b1, 1'b0));
        run_op(4'd7, 4'd9, 1'b1, 1'b0, 1'b0, 0, "post_rst");

        for (int i = 0; i < 25; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic ras;
            logic rbs;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            ras = 1'($urandom_range(0, 1));
            rbs = 1'($urandom_range(0, 1));
            exp_q.push_back(model(ra, rb, ras, rbs));
            run_op(ra, rb, ras, rbs, 1'($urandom_range(0, 1)), 0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
